sign_narrowing_unit: RTL and testbench
======================================

// Module: sign_narrowing_unit
//
// PURPOSE
//   Inverse of the 16->32 immediate sign extender: narrows signed IN_W-bit datapath
//   words to signed OUT_W-bit halfwords for halfword store/export paths.
//   Flags every word that does not fit in OUT_W signed bits and counts overflows.
//   Input and output use valid/ready handshakes, decoupled by a DEPTH-entry FIFO.
//   Sits between the ALU/register-file result bus and the halfword memory/port interface.
//
// PARAMETERS
//   IN_W   32  input word width (signed)
//   OUT_W  16  output width (signed); must satisfy 2 <= OUT_W < IN_W
//   DEPTH  2   output FIFO entries; power of two, >= 2
//   CNT_W  8   width of the overflow event counter
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_data is valid this cycle
//   in_ready   out  1      unit accepts a word this cycle (FIFO not full)
//   in_data    in   IN_W   signed word to narrow
//   out_valid  out  1      FIFO head is valid
//   out_ready  in   1      consumer takes the FIFO head this cycle
//   out_data   out  OUT_W  narrowed halfword (FIFO head)
//   out_ovf    out  1      FIFO head did not fit in OUT_W signed bits
//   clr_count  in   1      synchronous clear of ovf_count
//   ovf_count  out  CNT_W  saturating count of accepted overflowing words
//
// BEHAVIOUR
// - Reset (rst_n=0, async): FIFO empty, out_valid=0, in_ready=1, out_data=0, out_ovf=0, ovf_count=0.
// - Push = in_valid & in_ready.
// - Pop = out_valid & out_ready.
// - Fit test: word fits iff in_data[IN_W-1:OUT_W-1] is all 0s or all 1s.
// - ovf = ~fit.
// - Wrap mode: out_data = in_data[OUT_W-1:0]. The result is stored with its ovf flag in one FIFO entry.
// - Latency: a push into an empty FIFO gives out_valid=1 on the next rising edge. No combinational in->out path.
// - in_ready = ~full. It is derived from registered occupancy only and is independent of out_ready.
//   Consequences:
//   - No push while full, even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle with 0 < occupancy < DEPTH leave occupancy unchanged.
// - Order is strictly FIFO. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   An extra occupancy bit distinguishes full from empty.
// - out_data/out_ovf stay stable while out_valid=1 and out_ready=0.
// - When empty, out_data/out_ovf hold their last value.
// - in_valid while in_ready=0: the word is not taken. The producer must hold it.
// - ovf_count increments by 1 on each push with ovf=1 and saturates at all-ones (no wrap).
//   clr_count=1 forces ovf_count to 0 that cycle and wins over a simultaneous overflow push;
//   that event is not counted.
// - Invariant: when out_ovf=0, sign-extending out_data to IN_W equals the original in_data.
// - Reset asserted mid-transfer discards all FIFO contents and clears the counter immediately.
//   No partial output is presented after reset release.
//
// CONFIGURATION
// - Macro SIGN_NARROW_SATURATE_EN.
// - Defined: overflowing words saturate. in_data[IN_W-1]=0 gives out_data = 0 followed by
//   (OUT_W-1) ones, i.e. 16'h7FFF. in_data[IN_W-1]=1 gives 1 followed by (OUT_W-1) zeros, i.e. 16'h8000.
//   out_ovf and ovf_count behave as in wrap mode.
// - Undefined: wrap mode as above, i.e. plain truncation.
// - Fitting words are identical in both modes.
//
// TESTING
// - Reset, then push 32'hFFFF_FFFE:
//   - out_valid next cycle, out_data=16'hFFFE, out_ovf=0, ovf_count=0.
// - Push 32'h0001_2345:
//   - wrap mode: out_data=16'h2345.
//   - saturate mode: out_data=16'h7FFF.
//   - both modes: out_ovf=1, ovf_count=1.
// - Boundaries:
//   - 32'h0000_7FFF and 32'hFFFF_8000 give ovf=0.
//   - 32'h0000_8000 gives ovf=1 (saturate: 16'h7FFF).
//   - 32'hFFFF_7FFF gives ovf=1 (saturate: 16'h8000).
// - Hold out_ready=0 and push 3 words:
//   - in_ready drops after 2 pushes and the third word waits.
//   - Raising out_ready drains words in order, one per cycle, and in_ready returns the cycle after the first pop.
// - Drive 300 overflowing pushes with CNT_W=8:
//   - ovf_count sticks at 8'hFF.
//   - clr_count coincident with an overflow push gives ovf_count=0 the next cycle.
// - With the FIFO holding 2 words, pulse rst_n low between clock edges:
//   - out_valid=0, in_ready=1 and ovf_count=0 immediately.
//   - No stale word appears after release.

Source files
------------

// File: rtl/sign_narrowing_unit.sv
// Narrows signed IN_W-bit words to OUT_W bits, flags/counts overflow, buffers results in a small FIFO.
// Optional macro SIGN_NARROW_SATURATE_EN: overflowing words clamp to the signed OUT_W limits instead of truncating.
module sign_narrowing_unit #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);
    localparam int AW = $clog2(DEPTH);

    logic [OUT_W-1:0]     mem_data [DEPTH];
    logic                 mem_ovf  [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        rd_next;
    logic [AW:0]          occ;
    logic [AW:0]          occ_next;
    logic [IN_W-OUT_W:0]  upper;
    logic                 push;
    logic                 pop;
    logic                 fit;
    logic                 ovf;
    logic [OUT_W-1:0]     narrowed;

    assign upper     = in_data[IN_W-1:OUT_W-1];
    assign fit       = (&upper) | ~(|upper);
    assign ovf       = ~fit;
    assign in_ready  = ~occ[AW];
    assign out_valid = |occ;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef SIGN_NARROW_SATURATE_EN
    assign narrowed = ovf ? {in_data[IN_W-1], {(OUT_W-1){~in_data[IN_W-1]}}}
                          : in_data[OUT_W-1:0];
`else
    assign narrowed = in_data[OUT_W-1:0];
`endif

    always_comb begin
        rd_next  = rd_ptr;
        occ_next = occ;
        if (pop) begin
            rd_next = rd_ptr + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= narrowed;
            mem_ovf[wr_ptr]  <= ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            occ    <= occ_next;
            rd_ptr <= rd_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Head register: holds its last value when empty; a push into an
    // otherwise-empty FIFO bypasses storage so it appears next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (occ_next != '0) begin
            if (push && (rd_next == wr_ptr)) begin
                out_data <= narrowed;
                out_ovf  <= ovf;
            end else begin
                out_data <= mem_data[rd_next];
                out_ovf  <= mem_ovf[rd_next];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (clr_count) begin
            ovf_count <= '0;
        end else if (push && ovf && !(&ovf_count)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_sign_narrowing_unit.sv
// Directed self-checking bench for sign_narrowing_unit (default parameters).
module tb_sign_narrowing_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        clr_count;
    logic [7:0]  ovf_count;

    int checks = 0;
    int failures = 0;

`ifdef SIGN_NARROW_SATURATE_EN
    localparam logic [15:0] EXP_12345 = 16'h7FFF;
    localparam logic [15:0] EXP_08000 = 16'h7FFF;
    localparam logic [15:0] EXP_F7FFF = 16'h8000;
`else
    localparam logic [15:0] EXP_12345 = 16'h2345;
    localparam logic [15:0] EXP_08000 = 16'h8000;
    localparam logic [15:0] EXP_F7FFF = 16'h7FFF;
`endif

    sign_narrowing_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout reached");
        $fatal(1, "[TB] simulation time limit");
    end

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_word();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_count = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
        checks++; if (ovf_count !== 8'h00) begin failures++; $display("FAIL reset_ovf_count got=%h exp=00", ovf_count); end
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_first_push();
        push_word(32'hFFFF_FFFE);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'hFFFE) begin failures++; $display("FAIL first_data got=%h exp=FFFE", out_data); end
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL first_ovf got=%b exp=0", out_ovf); end
        checks++; if (ovf_count !== 8'h00) begin failures++; $display("FAIL first_count got=%h exp=00", ovf_count); end
        pop_word();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL first_empty got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'hFFFE) begin failures++; $display("FAIL first_hold got=%h exp=FFFE", out_data); end
    endtask

    task automatic test_overflow();
        push_word(32'h0001_2345);
        checks++; if (out_data !== EXP_12345) begin failures++; $display("FAIL ovf_data got=%h exp=%h", out_data, EXP_12345); end
        checks++; if (out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", out_ovf); end
        checks++; if (ovf_count !== 8'h01) begin failures++; $display("FAIL ovf_count got=%h exp=01", ovf_count); end
        pop_word();
    endtask

    task automatic test_boundaries();
        logic [31:0] vin  [4];
        logic [15:0] vout [4];
        logic        vovf [4];
        vin[0] = 32'h0000_7FFF; vout[0] = 16'h7FFF;  vovf[0] = 1'b0;
        vin[1] = 32'hFFFF_8000; vout[1] = 16'h8000;  vovf[1] = 1'b0;
        vin[2] = 32'h0000_8000; vout[2] = EXP_08000; vovf[2] = 1'b1;
        vin[3] = 32'hFFFF_7FFF; vout[3] = EXP_F7FFF; vovf[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_word(vin[i]);
            checks++; if (out_data !== vout[i]) begin failures++; $display("FAIL bound_data[%0d] got=%h exp=%h", i, out_data, vout[i]); end
            checks++; if (out_ovf !== vovf[i]) begin failures++; $display("FAIL bound_ovf[%0d] got=%b exp=%b", i, out_ovf, vovf[i]); end
            pop_word();
        end
        checks++; if (ovf_count !== 8'h03) begin failures++; $display("FAIL bound_count got=%h exp=03", ovf_count); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0011;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
        in_data = 32'h0000_0022;
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
        in_data = 32'hFFFF_FFCC;
        step();
        checks++; if (out_data !== 16'h0011) begin failures++; $display("FAIL b2b_stall_data got=%h exp=0011", out_data); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_still_full got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 16'h0022) begin failures++; $display("FAIL b2b_second got=%h exp=0022", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 16'hFFCC) begin failures++; $display("FAIL b2b_third got=%h exp=FFCC", out_data); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_third_valid got=%b exp=1", out_valid); end
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
        checks++; if (ovf_count !== 8'h03) begin failures++; $display("FAIL b2b_count got=%h exp=03", ovf_count); end
    endtask

    task automatic test_saturation();
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        checks++; if (ovf_count !== 8'h00) begin failures++; $display("FAIL clr_count got=%h exp=00", ovf_count); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h8000_0000;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 254) begin
                checks++; if (ovf_count !== 8'hFE) begin failures++; $display("FAIL sat_254 got=%h exp=FE", ovf_count); end
            end
        end
        checks++; if (ovf_count !== 8'hFF) begin failures++; $display("FAIL sat_300 got=%h exp=FF", ovf_count); end
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        checks++; if (ovf_count !== 8'h00) begin failures++; $display("FAIL clr_wins got=%h exp=00", ovf_count); end
        step();
        in_valid = 1'b0;
        checks++; if (ovf_count !== 8'h01) begin failures++; $display("FAIL after_clr got=%h exp=01", ovf_count); end
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        push_word(32'h0001_0000);
        push_word(32'h0002_0000);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL pre_reset valid=%b ready=%b exp=1/0", out_valid, in_ready); end
        checks++; if (ovf_count !== 8'h03) begin failures++; $display("FAIL pre_reset_count got=%h exp=03", ovf_count); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
        checks++; if (ovf_count !== 8'h00) begin failures++; $display("FAIL arst_count got=%h exp=00", ovf_count); end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid[%0d] got=%b exp=0", i, out_valid); end
        end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL post_reset_data got=%h exp=0000", out_data); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_overflow();
        test_boundaries();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
